// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg: shared types and AXI4-Lite encodings for the CPU bus bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package soc_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AR   = 3'd1,
      R    = 3'd2,
      AWW  = 3'd3,
      B    = 3'd4,
      RESP = 3'd5
   } bridge_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_PROT_INSTR  = 3'b100;
   localparam logic [2:0] AXI_PROT_DATA   = 3'b000;

   // EXOKAY cannot occur on AXI4-Lite, so only SLVERR/DECERR flag an error.
   function automatic logic axi_resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arb2.sv
// ---------------------------------------------------------------------------
// bus_arb2: two-requester arbiter (IFU/LSU), fixed LSU priority or round-robin
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_arb2
   import soc_pkg::*;
#(
   parameter int LSU_PRIO = 1
)
(
   input  logic   clock,
   input  logic   reset,
   input  logic   req_ifu_i,
   input  logic   req_lsu_i,
   input  logic   take_i,
   output logic   gnt_valid_o,
   output owner_e gnt_o
);

   localparam logic FIXED_LSU = (LSU_PRIO != 0);

   owner_e last_q;

   // On a tie the LSU wins if it is fixed-priority or if the IFU went last.
   always_comb begin
      gnt_valid_o = req_ifu_i | req_lsu_i;
      gnt_o       = OWN_IFU;
      if (req_lsu_i && (!req_ifu_i || FIXED_LSU || (last_q == OWN_IFU))) begin
         gnt_o = OWN_LSU;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q <= OWN_IFU;
      end else if (take_i && gnt_valid_o) begin
         last_q <= gnt_o;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cpu_axil_bridge.sv
// ---------------------------------------------------------------------------
// cpu_axil_bridge: IFU + LSU memory ports onto one single-outstanding AXI4-Lite master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_axil_bridge
   import soc_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LSU_PRIO = 1
)
(
   input  logic                clock,
   input  logic                reset,

   input  logic                io_ifu_reqValid,
   input  logic [ADDR_W-1:0]   io_ifu_addr,
   output logic                io_ifu_respValid,
   output logic [DATA_W-1:0]   io_ifu_rdata,
   output logic                io_ifu_respErr,

   input  logic                io_lsu_reqValid,
   input  logic [ADDR_W-1:0]   io_lsu_addr,
   input  logic [1:0]          io_lsu_size,
   input  logic                io_lsu_wen,
   input  logic [DATA_W-1:0]   io_lsu_wdata,
   input  logic [DATA_W/8-1:0] io_lsu_wmask,
   output logic                io_lsu_respValid,
   output logic [DATA_W-1:0]   io_lsu_rdata,
   output logic                io_lsu_respErr,

   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [2:0]          m_awprot,
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_bvalid,
   output logic                m_bready,
   input  logic [1:0]          m_bresp,
   output logic                m_arvalid,
   input  logic                m_arready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [2:0]          m_arprot,
   input  logic                m_rvalid,
   output logic                m_rready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp
);

   localparam int STRB_W = DATA_W / 8;

   bridge_state_e       state_q;
   owner_e              owner_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wmask_q;
   logic [2:0]          arprot_q;
   logic                arvalid_q, rready_q;
   logic                awvalid_q, wvalid_q, bready_q;
   logic                aw_done_q, w_done_q;
   logic                ifu_resp_q, lsu_resp_q;
   logic                ifu_err_q, lsu_err_q;
   logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;

   logic                arb_valid;
   owner_e              arb_gnt;
   logic                aw_hs, w_hs;
   logic                unused_size;

   // The AXI4-Lite data path is always a full word; byte lanes come from wmask.
   assign unused_size = ^io_lsu_size;

   bus_arb2 #(
      .LSU_PRIO    (LSU_PRIO)
   ) u_arb (
      .clock       (clock),
      .reset       (reset),
      .req_ifu_i   (io_ifu_reqValid),
      .req_lsu_i   (io_lsu_reqValid),
      .take_i      (state_q == IDLE),
      .gnt_valid_o (arb_valid),
      .gnt_o       (arb_gnt)
   );

   assign aw_hs = awvalid_q & m_awready;
   assign w_hs  = wvalid_q  & m_wready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IFU;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         arprot_q    <= AXI_PROT_DATA;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         ifu_resp_q  <= 1'b0;
         lsu_resp_q  <= 1'b0;
         ifu_err_q   <= 1'b0;
         lsu_err_q   <= 1'b0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  owner_q <= arb_gnt;
                  if (arb_gnt == OWN_LSU) begin
                     addr_q  <= io_lsu_addr;
                     wdata_q <= io_lsu_wdata;
                     wmask_q <= io_lsu_wmask;
                     if (io_lsu_wen) begin
                        state_q   <= AWW;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                     end else begin
                        state_q   <= AR;
                        arvalid_q <= 1'b1;
                        arprot_q  <= AXI_PROT_DATA;
                     end
                  end else begin
                     addr_q    <= io_ifu_addr;
                     state_q   <= AR;
                     arvalid_q <= 1'b1;
                     arprot_q  <= AXI_PROT_INSTR;
                  end
               end
            end
            AR: begin
               if (arvalid_q && m_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= R;
               end
            end
            R: begin
               if (rready_q && m_rvalid) begin
                  rready_q <= 1'b0;
                  state_q  <= RESP;
                  if (owner_q == OWN_IFU) begin
                     ifu_resp_q  <= 1'b1;
                     ifu_rdata_q <= m_rdata;
                     ifu_err_q   <= axi_resp_is_err(m_rresp);
                  end else begin
                     lsu_resp_q  <= 1'b1;
                     lsu_rdata_q <= m_rdata;
                     lsu_err_q   <= axi_resp_is_err(m_rresp);
                  end
               end
            end
            AWW: begin
               // Address and data channels complete independently, in either order.
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= B;
               end
            end
            B: begin
               if (bready_q && m_bvalid) begin
                  bready_q    <= 1'b0;
                  lsu_resp_q  <= 1'b1;
                  lsu_rdata_q <= '0;
                  lsu_err_q   <= axi_resp_is_err(m_bresp);
                  state_q     <= RESP;
               end
            end
            RESP: begin
               ifu_resp_q <= 1'b0;
               lsu_resp_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m_awvalid        = awvalid_q;
   assign m_awaddr         = addr_q;
   assign m_awprot         = AXI_PROT_DATA;
   assign m_wvalid         = wvalid_q;
   assign m_wdata          = wdata_q;
   assign m_wstrb          = wmask_q;
   assign m_bready         = bready_q;
   assign m_arvalid        = arvalid_q;
   assign m_araddr         = addr_q;
   assign m_arprot         = arprot_q;
   assign m_rready         = rready_q;

   assign io_ifu_respValid = ifu_resp_q;
   assign io_ifu_rdata     = ifu_rdata_q;
   assign io_ifu_respErr   = ifu_err_q;
   assign io_lsu_respValid = lsu_resp_q;
   assign io_lsu_rdata     = lsu_rdata_q;
   assign io_lsu_respErr   = lsu_err_q;

endmodule

`default_nettype wire
